// File: rtl/vga_scan_timer.sv
// vga_scan_timer
//   640x480@60 scan generator running on the 25 MHz VGA_CLK. Publishes the
//   160x120 game-grid coordinate being scanned (xvga/yvga), accepts the colour
//   sprite_manager computes for that coordinate COLOR_LAT cycles later, and
//   drives sync, blank and RGB to the DAC so that all of them describe the
//   same pixel.  A one-cycle vblank_tick marks the start of vertical blank.
//
//   Pipeline:
//     p0 : h/v counters and the raw sync/active decode taken from them
//     p1 : grid coordinates (xvga/yvga), vblank_tick, and a delay line of
//          depth 1+COLOR_LAT for the raw sync/active bits
//     p2 : DAC output register, where the delayed sync/active meet the colour
//
//   Build option VGA_BORDER_EN: when defined, a 1-pixel white frame is drawn
//   around the active area (first/last column, first/last line), overriding
//   the colour input.  The border flag travels in the delay line beside the
//   active bit.  When undefined there is no override and no extra delay bits.

module vga_scan_timer #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SCALE_SHIFT = 2,
   parameter int COLOR_LAT   = 1
) (
   input  logic       VGA_CLK,
   input  logic       resetn,
   input  logic [2:0] color,
   output logic [7:0] xvga,
   output logic [6:0] yvga,
   output logic       vblank_tick,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B
);

   // Frame geometry
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   // Sync/active delay so that they line up with the returned colour
   localparam int PIPE_D  = 1 + COLOR_LAT;

   // Counter-width copies of the timing landmarks
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef VGA_BORDER_EN
   localparam logic [HW-1:0] H_EDGE_R = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] V_EDGE_B = VW'(V_ACTIVE - 1);
`endif

   // Expands one colour bit to a full 8-bit channel; blanking wins over
   // everything, the white override wins over the colour bit.
   function automatic logic [7:0] chan_level(input logic bit_on,
                                             input logic act,
                                             input logic force_white);
      logic [7:0] lvl;
      lvl = 8'h00;
      if (act && (bit_on || force_white)) begin
         lvl = 8'hFF;
      end
      return lvl;
   endfunction

   // Stage p0: scan position
   logic [HW-1:0] h_cnt_p0;
   logic [VW-1:0] v_cnt_p0;

   // Stage p0: raw decode of the scan position
   logic          h_act_p0;
   logic          v_act_p0;
   logic          hs_raw_p0;
   logic          vs_raw_p0;
   logic          act_raw_p0;
   logic          tick_raw_p0;
   logic [7:0]    x_nxt_p0;
   logic [6:0]    y_nxt_p0;

   // Stage p1: delay line for sync/active, index PIPE_D-1 is the aligned end
   logic [PIPE_D-1:0] hs_dly_p1;
   logic [PIPE_D-1:0] vs_dly_p1;
   logic [PIPE_D-1:0] act_dly_p1;

   // Aligned view of the delay line as seen by the output register
   logic          hs_al;
   logic          vs_al;
   logic          act_al;
   logic          white_al;

`ifdef VGA_BORDER_EN
   logic              border_raw_p0;
   logic [PIPE_D-1:0] border_dly_p1;
`endif

   // Stage p0: horizontal counter wraps every line, vertical steps on that wrap
   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         h_cnt_p0 <= '0;
         v_cnt_p0 <= '0;
      end else begin
         if (h_cnt_p0 == H_LAST) begin
            h_cnt_p0 <= '0;
            if (v_cnt_p0 == V_LAST) begin
               v_cnt_p0 <= '0;
            end else begin
               v_cnt_p0 <= v_cnt_p0 + VW'(1);
            end
         end else begin
            h_cnt_p0 <= h_cnt_p0 + HW'(1);
         end
      end
   end

   // Stage p0: decode sync windows, active area, grid cell and vblank start
   always_comb begin
      h_act_p0    = 1'b0;
      v_act_p0    = 1'b0;
      hs_raw_p0   = 1'b1;
      vs_raw_p0   = 1'b1;
      act_raw_p0  = 1'b0;
      tick_raw_p0 = 1'b0;
      x_nxt_p0    = '0;
      y_nxt_p0    = '0;

      h_act_p0    = (h_cnt_p0 < H_ACT_L);
      v_act_p0    = (v_cnt_p0 < V_ACT_L);
      hs_raw_p0   = ~((h_cnt_p0 >= HS_BEG) && (h_cnt_p0 <= HS_END));
      vs_raw_p0   = ~((v_cnt_p0 >= VS_BEG) && (v_cnt_p0 <= VS_END));
      act_raw_p0  = h_act_p0 && v_act_p0;
      tick_raw_p0 = (h_cnt_p0 == '0) && (v_cnt_p0 == V_ACT_L);

      // Outside the active span the grid coordinate parks at 0
      if (h_act_p0) begin
         x_nxt_p0 = 8'(h_cnt_p0 >> SCALE_SHIFT);
      end
      if (v_act_p0) begin
         y_nxt_p0 = 7'(v_cnt_p0 >> SCALE_SHIFT);
      end
   end

`ifdef VGA_BORDER_EN
   // Stage p0: flag the outermost ring of active pixels
   always_comb begin
      border_raw_p0 = 1'b0;
      border_raw_p0 = (h_cnt_p0 == '0) || (h_cnt_p0 == H_EDGE_R) ||
                      (v_cnt_p0 == '0) || (v_cnt_p0 == V_EDGE_B);
   end
`endif

   // Stage p1: grid coordinates for sprite_manager and the vblank pulse
   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         xvga        <= '0;
         yvga        <= '0;
         vblank_tick <= 1'b0;
      end else begin
         xvga        <= x_nxt_p0;
         yvga        <= y_nxt_p0;
         vblank_tick <= tick_raw_p0;
      end
   end

   // Stage p1: delay sync/active by 1+COLOR_LAT so they meet the returned colour
   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         hs_dly_p1  <= '1;
         vs_dly_p1  <= '1;
         act_dly_p1 <= '0;
      end else begin
         hs_dly_p1[0]  <= hs_raw_p0;
         vs_dly_p1[0]  <= vs_raw_p0;
         act_dly_p1[0] <= act_raw_p0;
         for (int i = 1; i < PIPE_D; i++) begin
            hs_dly_p1[i]  <= hs_dly_p1[i-1];
            vs_dly_p1[i]  <= vs_dly_p1[i-1];
            act_dly_p1[i] <= act_dly_p1[i-1];
         end
      end
   end

`ifdef VGA_BORDER_EN
   // Stage p1: border flag rides the same delay as the active bit
   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         border_dly_p1 <= '0;
      end else begin
         border_dly_p1[0] <= border_raw_p0;
         for (int i = 1; i < PIPE_D; i++) begin
            border_dly_p1[i] <= border_dly_p1[i-1];
         end
      end
   end
`endif

   // Stage p1/p2 boundary: pick the aligned end of the delay line
   always_comb begin
      hs_al    = hs_dly_p1[PIPE_D-1];
      vs_al    = vs_dly_p1[PIPE_D-1];
      act_al   = act_dly_p1[PIPE_D-1];
`ifdef VGA_BORDER_EN
      white_al = border_dly_p1[PIPE_D-1];
`else
      white_al = 1'b0;
`endif
   end

   // Stage p2: DAC register, sync/blank and RGB all describe the same pixel
   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= 8'h00;
         VGA_G       <= 8'h00;
         VGA_B       <= 8'h00;
      end else begin
         VGA_HS      <= hs_al;
         VGA_VS      <= vs_al;
         VGA_BLANK_N <= act_al;
         VGA_R       <= chan_level(color[2], act_al, white_al);
         VGA_G       <= chan_level(color[1], act_al, white_al);
         VGA_B       <= chan_level(color[0], act_al, white_al);
      end
   end

endmodule
